// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture controller.
package adc_capture_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Default ADC resolution per channel.
    localparam int unsigned AdcResDflt = 14;

    // Packed sample pair {ch_B, ch_A}.
    localparam int unsigned DataW = 2 * AdcResDflt;

    // FIFO entry: sample pair plus the tlast marker in the MSB.
    localparam int unsigned EntryW = DataW + 1;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO holding captured sample pairs for the output stream.
// A write while full is dropped, even when a read happens in the same cycle.
// Flush empties the FIFO and takes priority over reads and writes.
module capture_fifo
    import adc_capture_pkg::*;
#(
    parameter int unsigned Width = EntryW,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    // Pointers carry one extra wrap bit to tell full from empty.
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [AddrW:0]   r_wr_ptr;
    logic [AddrW:0]   r_rd_ptr;
    logic [Width-1:0] r_mem [Depth];

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);

    // Fullness is judged before this cycle's read: no write-through when full.
    assign w_wr = wr_en_i && !w_full && !flush_i;
    assign w_rd = rd_en_i && !w_empty && !flush_i;

    // Pointer update; flush collapses both pointers to empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AddrW + 1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (AddrW + 1)'(1);
            end
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset; validity is tracked by the pointers,
    // so stale contents are never observable and the array can map to RAM.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AddrW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr[AddrW-1:0]];
    assign full_o    = w_full;
    assign empty_o   = w_empty;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller between the ADC channel demux and a stream consumer.
// Arms on request, waits for a fresh trigger rising edge, counts a fixed number of
// sample pairs (dropping, and flagging, pairs that find the buffer full) and drains
// the buffer over a valid/ready stream with a last marker on the final counted pair.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned AdcRes    = AdcResDflt,
    parameter int unsigned CntW      = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  trig_i,
    input  logic [CntW-1:0]       num_samples_i,
    input  logic                  adc_valid_i,
    input  logic [AdcRes-1:0]     ch_A_i,
    input  logic [AdcRes-1:0]     ch_B_i,
    output logic                  demux_en_o,
    output logic [2*AdcRes-1:0]   m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    localparam int unsigned PairW = 2 * AdcRes;

    state_t r_state;
    state_t w_state_nxt;

    logic            r_trig_q;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] r_num;
    logic            r_overflow;
    logic            r_done;

    logic            w_trig_edge;
    logic            w_arm_ok;
    logic            w_sample;
    logic            w_last_pair;
    logic            w_demux_en;
    logic            w_flush;
    logic            w_fifo_wr;
    logic            w_drain_done;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [PairW:0]  w_fifo_wdata;
    logic [PairW:0]  w_fifo_rdata;

    // A trigger is a rising edge seen against last cycle's level, so a level that
    // is already high when arming never starts a capture.
    assign w_trig_edge = trig_i && !r_trig_q;

    // Arm is honoured only from IDLE with a non-zero count; abort overrides it.
    assign w_arm_ok = (r_state == IDLE) && arm_i && (num_samples_i != '0) && !abort_i;

    // A counted pair: every valid in CAPTURE, whether or not the buffer takes it.
    assign w_sample = (r_state == CAPTURE) && adc_valid_i && !abort_i;

    // Terminal compare against the latched count, never the live input.
    assign w_last_pair = (r_cnt == (r_num - CntW'(1)));

    assign w_fifo_wdata = {w_last_pair, ch_B_i, ch_A_i};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode; abort is applied last so it wins.
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results within the same evaluation; clocked blocks use '<=' only.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_demux_en   = 1'b0;
        w_flush      = 1'b0;
        w_fifo_wr    = 1'b0;
        w_drain_done = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_arm_ok) begin
                    w_flush     = 1'b1;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                w_demux_en = 1'b1;
                if (w_trig_edge) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_demux_en = 1'b1;
                if (adc_valid_i) begin
                    w_fifo_wr = 1'b1;
                    if (w_last_pair) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_fifo_empty) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (abort_i) begin
            w_state_nxt  = IDLE;
            w_flush      = 1'b1;
            w_fifo_wr    = 1'b0;
            w_drain_done = 1'b0;
        end
    end

    // Trigger history, latched count, pair counter, sticky overflow and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig_q   <= 1'b0;
            r_cnt      <= '0;
            r_num      <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_trig_q <= trig_i;
            r_done   <= w_drain_done;
            if (w_arm_ok) begin
                r_num      <= num_samples_i;
                r_cnt      <= '0;
                r_overflow <= 1'b0;
            end else if (w_sample) begin
                // The window is fixed in time: dropped pairs still advance the count.
                r_cnt <= r_cnt + CntW'(1);
                if (w_fifo_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    capture_fifo #(
        .Width (PairW + 1),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (w_flush),
        .wr_en_i   (w_fifo_wr),
        .wr_data_i (w_fifo_wdata),
        .rd_en_i   (m_tready_i),
        .rd_data_o (w_fifo_rdata),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    // Head of the buffer is presented directly; it is zeroed while empty so the
    // stream outputs read 0 after reset and flush rather than stale storage.
    assign m_tvalid_o = !w_fifo_empty;
    assign m_tdata_o  = w_fifo_empty ? '0 : w_fifo_rdata[PairW-1:0];
    assign m_tlast_o  = !w_fifo_empty && w_fifo_rdata[PairW];

    // The demux runs only while waiting for or taking samples.
    assign demux_en_o = w_demux_en;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = r_done;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: the stimulus side keeps a transaction
// model of buffer occupancy and pushes every pair the design should emit into a
// scoreboard queue; an independent monitor pops and compares on each stream beat.
module tb_adc_capture_ctrl;

    localparam int AdcRes    = 14;
    localparam int CntW      = 16;
    localparam int FifoDepth = 4;
    localparam int PairW     = 2 * AdcRes;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              abort;
    logic              trig;
    logic [CntW-1:0]   num;
    logic              adc_valid;
    logic [AdcRes-1:0] ch_a;
    logic [AdcRes-1:0] ch_b;
    logic              ready;

    logic              demux_en;
    logic [PairW-1:0]  tdata;
    logic              tvalid;
    logic              tlast;
    logic              busy;
    logic              done;
    logic              overflow;

    adc_capture_ctrl #(
        .AdcRes    (AdcRes),
        .CntW      (CntW),
        .FifoDepth (FifoDepth)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .arm_i         (arm),
        .abort_i       (abort),
        .trig_i        (trig),
        .num_samples_i (num),
        .adc_valid_i   (adc_valid),
        .ch_A_i        (ch_a),
        .ch_B_i        (ch_b),
        .demux_en_o    (demux_en),
        .m_tdata_o     (tdata),
        .m_tvalid_o    (tvalid),
        .m_tready_i    (ready),
        .m_tlast_o     (tlast),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected beats {tlast, ch_B, ch_A}.
    logic [PairW:0] sb [$];

    // Reference model state for the current capture.
    int m_occ    = 0;
    int m_cnt    = 0;
    int m_pushed = 0;
    bit m_ovf    = 1'b0;

    // Monitor-side counters.
    int done_cnt = 0;
    int beat_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every transferred beat and checks stream stability under stall.
    logic           prev_stall = 1'b0;
    logic           prev_abort = 1'b0;
    logic [PairW:0] prev_beat  = '0;
    logic [PairW:0] exp_beat;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall && !prev_abort) begin
                check("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_beat});
            end
            if (tvalid && ready) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {tlast, tdata});
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat", {tlast, tdata}, exp_beat);
                end
            end
            prev_stall = tvalid && !ready;
            prev_beat  = {tlast, tdata};
            prev_abort = abort;
        end
    end

    // One clock of stimulus. The model applies the capture rules: a pair in the
    // capture window is kept if fewer than FifoDepth entries are held at that
    // edge, otherwise it is lost and overflow is flagged; a held entry leaves
    // whenever ready is high.
    task automatic step(input bit v, input bit rdy, input bit cap,
                        input logic [AdcRes-1:0] a, input logic [AdcRes-1:0] b,
                        input int n);
        bit pop;
        adc_valid = v;
        ready     = rdy;
        ch_a      = a;
        ch_b      = b;
        pop = rdy && (m_occ > 0);
        if (cap && v) begin
            if (m_occ < FifoDepth) begin
                sb.push_back({(m_cnt == n - 1), b, a});
                m_occ++;
                m_pushed++;
            end else begin
                m_ovf = 1'b1;
            end
            m_cnt++;
        end
        if (pop) m_occ--;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, rdy, 1'b0, '0, '0, 1);
    endtask

    // Arm with count n, then spend npre cycles in ARMED with random (discarded) samples.
    task automatic arm_capture(input string tag, input int n, input int npre);
        m_cnt    = 0;
        m_pushed = 0;
        m_ovf    = 1'b0;
        num = CntW'(n);
        arm = 1'b1;
        idle_step(1'b0);
        arm = 1'b0;
        num = CntW'($urandom);
        check({tag, "_armed_busy"}, busy, 1);
        check({tag, "_armed_demux_en"}, demux_en, 1);
        for (int i = 0; i < npre; i++) begin
            step(1'($urandom), 1'($urandom), 1'b0, AdcRes'($urandom), AdcRes'($urandom), n);
        end
    endtask

    // One-cycle trigger pulse, carrying a sample that must be discarded.
    task automatic trigger();
        trig = 1'b1;
        step(1'b1, 1'($urandom), 1'b0, AdcRes'($urandom), AdcRes'($urandom), 1);
        trig = 1'b0;
    endtask

    task automatic capture_random(input int n, input int vpct, input int rpct);
        int g = 0;
        while (m_cnt < n && g < 2000) begin
            step(($urandom_range(0, 99) < vpct), ($urandom_range(0, 99) < rpct), 1'b1,
                 AdcRes'($urandom), AdcRes'($urandom), n);
            g++;
        end
        check("capture_window_closed", (m_cnt == n), 1);
    endtask

    // Drain until done, then check completion status against the model.
    task automatic finish_drain(input string tag, input int drpct, input int d0, input int b0);
        int g = 0;
        while (!done && g < 300) begin
            idle_step($urandom_range(0, 99) < drpct);
            g++;
        end
        check({tag, "_done_seen"}, done, 1);
        idle_step(1'b0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_beats"}, beat_cnt - b0, m_pushed);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_overflow"}, overflow, m_ovf);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_tvalid"}, tvalid, 0);
    endtask

    task automatic run_capture(input string tag, input int n, input int vpct,
                               input int rpct, input int drpct);
        int d0 = done_cnt;
        int b0 = beat_cnt;
        arm_capture(tag, n, $urandom_range(0, 3));
        trigger();
        capture_random(n, vpct, rpct);
        finish_drain(tag, drpct, d0, b0);
    endtask

    initial begin : main
        int d0;
        int b0;

        rst       = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        trig      = 1'b0;
        num       = '0;
        adc_valid = 1'b0;
        ch_a      = '0;
        ch_b      = '0;
        ready     = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        check("reset_outputs", {demux_en, tvalid, tlast, busy, done, overflow}, 6'b0);
        check("reset_tdata", tdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_step(1'b1);

        // Arm with a zero count is ignored.
        num = '0;
        arm = 1'b1;
        idle_step(1'b1);
        arm = 1'b0;
        check("zero_arm_busy", busy, 0);
        check("zero_arm_demux_en", demux_en, 0);

        // Basic capture of four pairs with ready held high.
        d0 = done_cnt;
        b0 = beat_cnt;
        arm_capture("basic", 4, 2);
        trigger();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, AdcRes'(14'h100 + i), AdcRes'(14'h200 + i), 4);
            if (i == 0) check("basic_latency_tvalid", tvalid, 1);
        end
        check("basic_drain_demux_en", demux_en, 0);
        check("basic_drain_busy", busy, 1);
        finish_drain("basic", 100, d0, b0);

        // Backpressure: eight pairs into a four-entry buffer with ready low.
        d0 = done_cnt;
        b0 = beat_cnt;
        arm_capture("ovf", 8, 1);
        trigger();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, AdcRes'($urandom), AdcRes'($urandom), 8);
        end
        check("ovf_flag_set", overflow, 1);
        check("ovf_tvalid_held", tvalid, 1);
        check("ovf_no_tlast_at_head", tlast, 0);
        finish_drain("ovf", 100, d0, b0);

        // Abort after two of six pairs.
        d0 = done_cnt;
        arm_capture("abort", 6, 1);
        trigger();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, AdcRes'($urandom), AdcRes'($urandom), 6);
        end
        abort = 1'b1;
        step(1'b1, 1'b0, 1'b0, AdcRes'($urandom), AdcRes'($urandom), 6);
        abort = 1'b0;
        sb.delete();
        m_occ = 0;
        check("abort_busy", busy, 0);
        check("abort_tvalid", tvalid, 0);
        check("abort_overflow", overflow, 0);
        for (int i = 0; i < 3; i++) idle_step(1'b1);
        check("abort_no_done", done_cnt - d0, 0);

        // Abort after an overflow keeps the flag; a concurrent arm is ignored.
        d0 = done_cnt;
        arm_capture("abort_ovf", 8, 0);
        trigger();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1, AdcRes'($urandom), AdcRes'($urandom), 8);
        end
        abort = 1'b1;
        arm   = 1'b1;
        num   = 16'd3;
        step(1'b1, 1'b0, 1'b0, AdcRes'($urandom), AdcRes'($urandom), 8);
        abort = 1'b0;
        arm   = 1'b0;
        sb.delete();
        m_occ = 0;
        check("abort_ovf_busy", busy, 0);
        check("abort_ovf_flag_kept", overflow, 1);
        for (int i = 0; i < 3; i++) idle_step(1'b1);
        check("abort_ovf_no_done", done_cnt - d0, 0);
        check("abort_ovf_still_idle", busy, 0);

        // Trigger already high at arm: needs a fresh rising edge.
        d0 = done_cnt;
        b0 = beat_cnt;
        trig = 1'b1;
        idle_step(1'b1);
        arm_capture("held_trig", 3, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, AdcRes'($urandom), AdcRes'($urandom), 3);
        end
        check("held_trig_still_armed", busy, 1);
        check("held_trig_no_tvalid", tvalid, 0);
        trig = 1'b0;
        idle_step(1'b1);
        trigger();
        capture_random(3, 100, 100);
        finish_drain("held_trig", 100, d0, b0);

        // Asynchronous reset in the middle of a capture.
        arm_capture("rst_mid", 5, 0);
        trigger();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, AdcRes'($urandom), AdcRes'($urandom), 5);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {demux_en, tvalid, tlast, busy, done, overflow}, 6'b0);
        check("rst_mid_tdata", tdata, 0);
        sb.delete();
        m_occ = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_capture("post_rst", 2, 100, 100, 100);

        // Randomised captures.
        for (int k = 0; k < 8; k++) begin
            run_capture($sformatf("rand%0d", k), $urandom_range(1, 10),
                        $urandom_range(40, 100), $urandom_range(0, 100),
                        $urandom_range(30, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences the ADC channel demultiplexer for triggered captures:
  - drives its clock enable;
  - accepts its valid / channel A / channel B outputs;
  - counts a programmed number of sample pairs after a trigger edge;
  - streams them out over a valid/ready interface with a last marker.
- Sits between the demux and the DMA/stream consumer.
- Provides arm/abort control and done/overflow status to the register block.

Parameters:
- AdcRes, 14, ADC sample width per channel.
- CntW, 16, width of the sample-pair counter and of num_samples_i.
- FifoDepth, 4, output buffer entries. Power of two, minimum 2.

Ports:
- clk_i  in  1  Capture clock; same clock as the demux.
- rst_i  in  1  Asynchronous, active-high reset.
- arm_i  in  1  Single-cycle arm request.
- abort_i  in  1  Single-cycle abort request.
- trig_i  in  1  Level trigger, already synchronous to clk_i. Its rising edge starts capture.
- num_samples_i  in  CntW  Number of sample pairs per capture. Latched on arm.
- adc_valid_i  in  1  Demux valid.
- ch_A_i  in  AdcRes  Demux channel A.
- ch_B_i  in  AdcRes  Demux channel B.
- demux_en_o  out  1  Clock enable to the demux.
- m_tdata_o  out  2*AdcRes  Packed sample pair {ch_B, ch_A}.
- m_tvalid_o  out  1  Stream valid.
- m_tready_i  in  1  Stream ready.
- m_tlast_o  out  1  Marks the final counted pair.
- busy_o  out  1  High in every state except IDLE.
- done_o  out  1  One-cycle pulse on normal completion.
- overflow_o  out  1  Sticky flag; cleared on an accepted arm.

Behaviour:
- Reset values:
  - state = IDLE;
  - all outputs 0;
  - FIFO empty, counter 0, trigger edge register 0.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE:
  - An arm_i with num_samples_i != 0 latches the count, clears overflow_o, flushes the FIFO, and moves to ARMED.
  - An arm_i with num_samples_i == 0 is ignored.
  - arm_i in any other state is ignored.
- ARMED:
  - demux_en_o = 1.
  - Trigger edge = trig_i high while its registered copy is low.
  - On edge detection, go to CAPTURE next cycle.
  - Samples arriving in ARMED are discarded.
  - A trig_i that is already high when ARMED is entered does not trigger; a fresh rising edge is required.
- CAPTURE:
  - demux_en_o = 1.
  - Each adc_valid_i cycle increments the counter.
  - If the FIFO is not full, the pair is written with tlast = (count == latched-1).
  - If the FIFO is full, the pair is dropped, overflow_o is set, and the counter still increments. The capture window is fixed in time.
  - When the final pair is counted, go to DRAIN. demux_en_o drops in the cycle DRAIN is entered.
- DRAIN:
  - demux_en_o = 0; no writes.
  - When the FIFO is empty, pulse done_o for one cycle and return to IDLE.
- If the final pair was dropped, no beat carries m_tlast_o. Software detects this via overflow_o.
- FIFO:
  - Simultaneous read and write when full is not allowed: a write while full is dropped even if a read occurs that cycle.
  - Simultaneous read and write when non-empty and not full keeps the occupancy unchanged.
- Latency: adc_valid_i in CAPTURE → m_tvalid_o at the next cycle, when the FIFO was empty.
- Stream rules:
  - m_tdata_o and m_tlast_o are stable while m_tvalid_o=1 and m_tready_i=0.
  - A beat transfers on m_tvalid_o & m_tready_i.
- abort_i:
  - In any state, returns to IDLE next cycle.
  - Flushes the FIFO, deasserting m_tvalid_o.
  - No done_o pulse; overflow_o is preserved.
  - abort_i wins over a simultaneous arm_i, trigger, or final sample.
- Counter arithmetic: unsigned, CntW bits. The terminal compare uses the latched value, so num_samples_i changes mid-capture have no effect.
- Reset asserted mid-operation returns immediately to the reset values. No partial stream resumes.

Decomposition:
- Shared package adc_capture_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DRAIN);
  - localparam DataW = 2*AdcRes;
  - FIFO entry width DataW+1 (tlast bit).
- One sub-module, capture_fifo:
  - synchronous FIFO, FifoDepth entries, width DataW+1;
  - full/empty flags;
  - flush input.

Test Plan:
- Basic capture: num_samples=4, m_tready_i=1, trigger edge, adc_valid_i every cycle with A=0x100+i, B=0x200+i → 4 beats with tdata {0x200+i, 0x100+i}, tlast on beat 4 only, one done_o pulse, overflow_o=0, demux_en_o low in DRAIN.
- Backpressure overflow: num_samples=8, FifoDepth=4, m_tready_i=0 throughout capture → 4 entries held, overflow_o=1, no tlast. Then release ready → exactly 4 beats, then done_o.
- Abort: abort_i asserted during CAPTURE after 2 of 6 samples → IDLE next cycle, m_tvalid_o=0, busy_o=0, no done_o.
- Trigger rules:
  - arm with num_samples=0 → stays IDLE;
  - trig_i held high before arm → no capture until trig_i falls and rises again.
- Reset mid-capture: rst_i asserted asynchronously between clock edges → all outputs 0 immediately. After release, a normal num_samples=2 capture completes correctly.
- Samples in ARMED: adc_valid_i pulses before the trigger edge are not output; the count starts at the first valid after entering CAPTURE.
